load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extraction/extension and store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] mask;
    logic [31:0] lane_data;

    always_comb begin
        byte_shift = mem_word >> {lane, 3'b000};
        half_shift = mem_word >> {lane[1], 4'b0000};
        load_data  = mem_word;
        mask       = 32'hFFFF_FFFF;
        lane_data  = store_data;
        unique case (1'b1)
            size == SIZE_B: begin
                load_data = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
                mask      = 32'h0000_00FF << {lane, 3'b000};
                lane_data = {24'd0, store_data[7:0]} << {lane, 3'b000};
            end
            size == SIZE_H: begin
                load_data = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
                mask      = 32'h0000_FFFF << {lane[1], 4'b0000};
                lane_data = {16'd0, store_data[15:0]} << {lane[1], 4'b0000};
            end
            default: ;
        endcase
        // Untouched lanes keep the word just read from memory.
        merged_word = (mem_word & ~mask) | (lane_data & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] endereco,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    lsu_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] st_data_q, st_data_d;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    lsu_align u_align (
        .mem_word    (read_data),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .store_data  (st_data_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign accept  = req_valid && ready_q;
    assign req_err = (req_size == SIZE_X)
                  || (req_size == SIZE_H && req_addr[0])
                  || (req_size == SIZE_W && req_addr[1:0] != 2'b00)
                  || (req_addr >= ADDR_LIMIT);

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        addr_d       = addr_q;
        wdata_d      = 32'd0;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'd0;
        write_d      = write_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        st_data_d    = st_data_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                addr_d  = 32'd0;
                if (accept) begin
                    ready_d   = 1'b0;
                    write_d   = req_write;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    lane_d    = req_addr[1:0];
                    st_data_d = req_wdata;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_size == SIZE_W) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        addr_d      = {req_addr[31:2], 2'b00};
                        wdata_d     = req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                        addr_d     = {req_addr[31:2], 2'b00};
                    end
                end
            end
            RD: state_d = RD_CAP;
            RD_CAP: begin
                if (write_q) begin
                    state_d     = WR;
                    mem_write_d = 1'b1;
                    wdata_d     = merged_word;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    addr_d       = 32'd0;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                addr_d       = 32'd0;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            write_q      <= 1'b0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            st_data_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            st_data_q    <= st_data_d;
        end
    end

    assign req_ready  = ready_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign endereco   = addr_q;
    assign write_data = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: byte-array reference memory predicts every response.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] endereco;
    logic [31:0] write_data;
    logic [31:0] read_data;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_LIMIT(32'd1024)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .endereco     (endereco),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wword;
        int          stamp;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] bus_mem [0:255];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] seen_waddr = 32'd0;
    logic [31:0] seen_wword = 32'd0;

    always @(posedge clock) cyc <= cyc + 1;

    // Data memory: registered read, word write.
    always @(posedge clock) begin
        read_data <= $urandom;
        if (MemRead) read_data <= bus_mem[endereco[9:2]];
        if (MemWrite) bus_mem[endereco[9:2]] <= write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        ref_word = {ref_mem[wa+3], ref_mem[wa+2], ref_mem[wa+1], ref_mem[wa]};
    endfunction

    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
        int nb;
        logic [31:0] val;
        e = '{err: 1'b0, rdata: 32'd0, lat: 0, nrd: 0, nwr: 0,
              waddr: 32'd0, wword: 32'd0, stamp: 0};
        nb = 1 << sz;
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
            || a >= 32'd1024) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!w) begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8 * i));
            if (!u && sz == 2'd0) val = {{24{val[7]}}, val[7:0]};
            if (!u && sz == 2'd1) val = {{16{val[15]}}, val[15:0]};
            e.rdata = val;
            e.lat = 3;
            e.nrd = 1;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            e.waddr = a & ~32'd3;
            e.wword = ref_word(int'(e.waddr));
            e.nwr = 1;
            e.nrd = (sz == 2'd2) ? 0 : 1;
            e.lat = (sz == 2'd2) ? 2 : 4;
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (MemRead || MemWrite) begin
                chk("strobe_excl", 32'(MemRead & MemWrite), 32'd0);
                chk("addr_align", 32'(endereco[1:0]), 32'd0);
            end
            if (MemRead) rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                seen_waddr = endereco;
                seen_wword = write_data;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_error", 32'(resp_error), 32'(e.err));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.stamp), 32'(e.lat));
                    chk("memread_cnt", 32'(rd_cnt), 32'(e.nrd));
                    chk("memwrite_cnt", 32'(wr_cnt), 32'(e.nwr));
                    if (e.nwr > 0) begin
                        chk("wr_addr", seen_waddr, e.waddr);
                        chk("wr_word", seen_wword, e.wword);
                    end
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        int t;
        exp_t e;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
        end else begin
            model(w, sz, u, a, d, e);
            e.stamp = cyc;
            q.push_back(e);
            @(negedge clock);
        end
    endtask

    task automatic drain();
        int t;
        req_valid = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_memread"}, 32'(MemRead), 32'd0);
        chk({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
        chk({tag, "_endereco"}, endereco, 32'd0);
        chk({tag, "_write_data"}, write_data, 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]}     = 32'h0000_0005;
        {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}     = 32'h80FF_7F01;
        {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]}   = 32'h1122_3344;
        for (int i = 0; i < 256; i++) bus_mem[i] = ref_word(4 * i);

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("ready_after_edge", 32'(req_ready), 32'd1);

        issue(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
        issue(1'b0, 2'd0, 1'b0, 32'd6, 32'd0);
        issue(1'b0, 2'd1, 1'b1, 32'd6, 32'd0);
        issue(1'b0, 2'd1, 1'b0, 32'd6, 32'd0);
        issue(1'b1, 2'd0, 1'b0, 32'd9, 32'h0000_00AA);
        issue(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h2, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 32'h401, 32'h1234);
        issue(1'b0, 2'd3, 1'b0, 32'd4, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 32'd1024, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 32'd1023, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 32'd1022, 32'hBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'd1020, 32'd0);
        drain();

        // Reset while the word store is in its write cycle.
        req_write = 1'b1;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_addr = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        chk("ready_before_abort", 32'(req_ready), 32'd1);
        @(posedge clock);
        #2;
        chk("abort_memwrite_high", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("ready_before_edge2", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("ready_after_edge2", 32'(req_ready), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        drain();

        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) < 8) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) a = $urandom;
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clock);
            end
        end
        drain();

        for (int i = 0; i < 256; i++) chk("final_mem", bus_mem[i], ref_word(4 * i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
